ecc_scrub_memory: RTL and testbench
===================================

Name: ecc_scrub_memory

Overview:
Parametrised SECDED-protected word memory for instruction/data storage, the successor to the fixed 1024x32 Hamming instruction store. It adds a registered read port with a valid strobe, correct-on-read write-back, a background scrubber that walks the array and repairs single-bit upsets, and saturating error counters with last-error address capture. It sits between the loader/CPU fetch path and the core, with error outputs feeding the status/CSR logic.

Parameters:
DATA_W, 32, data word width in bits (≥8)
ADDR_W, 10, word-address width; depth = 2**ADDR_W words
SCRUB_INTERVAL, 256, idle cycles between scrubber word visits (≥2)
CNT_W, 16, width of the saturating error counters

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  write enable
waddr  in  ADDR_W  word write address
wdata  in  DATA_W  write data (encoded internally)
re  in  1  read enable
raddr  in  ADDR_W  word read address
rdata  out  DATA_W  corrected read data, valid when rvalid=1
rvalid  out  1  one-cycle strobe, read data ready
s_err  out  1  with rvalid: single-bit error corrected on this read
d_err  out  1  with rvalid: uncorrectable double error on this read
scrub_en  in  1  enables the background scrubber
scrub_s_cnt  out  CNT_W  single errors found (reads + scrubs), saturating
scrub_d_cnt  out  CNT_W  double errors found (reads + scrubs), saturating
err_addr  out  ADDR_W  address of most recent detected error
cnt_clr  in  1  synchronous clear of both counters

Behaviour:
- Code word: P = smallest p with 2**p ≥ DATA_W+p+1, plus one overall parity bit; CODE_W = DATA_W+P+1 (39 for DATA_W=32). Array: 2**ADDR_W x CODE_W. Array contents are not reset.
- Reset values: rdata=0, rvalid=0, s_err=0, d_err=0, counters=0, err_addr=0, scrubber in WAIT with interval counter=0 and scrub pointer=0.
- Write: if we, encode wdata and write mem[waddr] at the rising edge. Zero latency.
- Read: if re, sample mem[raddr] at the edge. Next cycle: rvalid=1, rdata=corrected data, s_err/d_err from syndrome. Latency is 1 cycle; back-to-back reads are fully pipelined. On d_err, rdata is the raw data bits, uncorrected.
- Read-after-write, same address, same cycle: the read returns the OLD word (read-first).
- Correct-on-read: on a CPU-read single error, the corrected word is re-encoded and written back in the following cycle if we=0 in that cycle. Otherwise the write-back is dropped, because the scrubber repairs it later.
- Scrubber FSM (active only when scrub_en=1; otherwise it is held in WAIT with the interval counter cleared):
  WAIT: count idle cycles; at SCRUB_INTERVAL-1 go to READ.
  READ: if re=0, read mem[ptr] and go to CHECK; else stay in READ, because CPU reads have priority.
  CHECK: decode. On a single error go to FIX. Otherwise increment ptr (wraps from 2**ADDR_W-1 to 0) and go to WAIT.
  FIX: if we=0, write the corrected re-encoded word to mem[ptr], increment ptr, and go to WAIT. If we=1 and waddr==ptr, cancel the fix (the fresh write wins), increment ptr, and go to WAIT. If we=1 and waddr!=ptr, stay in FIX.
- Double error in the scrubber: counted and err_addr captured; no write; ptr advances.
- Counters: +1 per detected event from a CPU read or a scrub CHECK. If both occur in the same cycle, the total increment is 2. Counters saturate at all-ones. cnt_clr has priority over increments.
- err_addr: updated on any detected error. If a CPU read and the scrubber both detect an error in the same cycle, the CPU read address wins.
- Reset mid-operation: the FSM returns to WAIT, a pending write-back is discarded, and array contents are preserved.
- s_err/d_err are 0 whenever rvalid=0.

Decomposition:
- Shared package holds: parity-count function calc_parity_bits(DATA_W), CODE_W derivation, and the scrubber state enum {WAIT, READ, CHECK, FIX}.
- Sub-module: secded_codec, a parametrised combinational encoder and decoder (syndrome, correction, s_err/d_err). Instantiate it three times: write encode, read decode, scrub decode/re-encode. Reuse the read-path decoder's re-encode output for the write-back.

Test Plan:
- Write 32'hDEADBEEF to addr 5, read addr 5 -> one cycle later rvalid=1, rdata=DEADBEEF, s_err=0, d_err=0.
- Backdoor-flip code bit 3 of addr 7 (holding 32'h12345678), read -> rdata=12345678, s_err=1, scrub_s_cnt=1, err_addr=7. Re-read -> s_err=0, confirming the write-back.
- Backdoor-flip two bits of addr 9, read -> d_err=1, s_err=0, scrub_d_cnt=1. The word stays corrupted on re-read.
- ADDR_W=3, SCRUB_INTERVAL=4, scrub_en=1, single-bit flips in all 8 words, no CPU traffic -> after about 8x(4+3) cycles scrub_s_cnt=8, all words read clean, and ptr has wrapped to 0.
- Scrubber in FIX for addr 2, assert we to waddr=2 with 32'hA5A5A5A5 -> fix cancelled and a later read returns A5A5A5A5. With waddr=3 instead -> FIX waits one cycle, then writes.
- Set counters to all-ones via repeated errors (CNT_W=2) -> the counter holds at 3. Pulse cnt_clr together with an error -> counter=0. Assert rst mid-FIX -> outputs zeroed and array contents unchanged.

Source files
------------

// File: rtl/ecc_scrub_memory_pkg.sv
// Shared definitions for the SECDED scrubbed memory: code-word sizing and scrubber states.
package ecc_scrub_memory_pkg;

  typedef enum logic [1:0] {WAIT, READ, CHECK, FIX} scrub_state_t;

  // Smallest p with 2**p >= data_w + p + 1 (Hamming check bits, excluding overall parity).
  function automatic int calc_parity_bits(input int data_w);
    int p;
    p = 1;
    while ((1 << p) < data_w + p + 1) p++;
    return p;
  endfunction

  function automatic int calc_code_w(input int data_w);
    return data_w + calc_parity_bits(data_w) + 1;
  endfunction

endpackage

// File: rtl/ecc_scrub_memory_codec.sv
// Combinational SECDED encoder plus decoder; bit 0 is overall parity, bits 1.. are Hamming positions.
module secded_codec
  import ecc_scrub_memory_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int CODE_W = calc_code_w(DATA_W)
) (
  input  logic [DATA_W-1:0] enc_data,
  output logic [CODE_W-1:0] enc_code,
  input  logic [CODE_W-1:0] dec_code,
  output logic [DATA_W-1:0] dec_data,
  output logic              s_err,
  output logic              d_err
);

  localparam int P = calc_parity_bits(DATA_W);

  function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic              par;
    int                j;
    c = '0;
    j = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        c[pos] = d[j];
        j++;
      end
    end
    for (int p = 0; p < P; p++) begin
      par = 1'b0;
      for (int pos = 1; pos < CODE_W; pos++)
        if (((pos >> p) & 1) == 1) par = par ^ c[pos];
      c[1 << p] = par;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int                j;
    d = '0;
    j = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        d[j] = c[pos];
        j++;
      end
    end
    return d;
  endfunction

  logic [P-1:0]      syn;
  logic              overall;
  logic [CODE_W-1:0] fixed;

  assign enc_code = encode(enc_data);

  // A syndrome pointing past the last code bit with odd parity is a multi-bit upset, not a single.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    syn   = '0;
    fixed = dec_code;
    for (int p = 0; p < P; p++)
      for (int pos = 1; pos < CODE_W; pos++)
        if (((pos >> p) & 1) == 1) syn[p] = syn[p] ^ dec_code[pos];
    overall = ^dec_code;
    s_err   = overall && (int'(syn) < CODE_W);
    d_err   = (!overall && (syn != '0)) || (overall && (int'(syn) >= CODE_W));
    for (int pos = 0; pos < CODE_W; pos++)
      if (s_err && (int'(syn) == pos)) fixed[pos] = ~dec_code[pos];
    dec_data = extract(d_err ? dec_code : fixed);
  end

endmodule

// File: rtl/ecc_scrub_memory.sv
// SECDED word memory with registered read, correct-on-read write-back, background scrubber
// and saturating error counters.
module ecc_scrub_memory
  import ecc_scrub_memory_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 10,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              s_err,
  output logic              d_err,
  input  logic              scrub_en,
  output logic [CNT_W-1:0]  scrub_s_cnt,
  output logic [CNT_W-1:0]  scrub_d_cnt,
  output logic [ADDR_W-1:0] err_addr,
  input  logic              cnt_clr
);

  localparam int CODE_W = calc_code_w(DATA_W);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int IW     = $clog2(SCRUB_INTERVAL);

  logic [CODE_W-1:0] mem [DEPTH];

  logic [CODE_W-1:0] wr_code;
  logic [DATA_W-1:0] unused_wr_data;
  logic              unused_wr_s, unused_wr_d;

  logic [CODE_W-1:0] rd_code_q, rd_fix_code;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_stale, rd_s, rd_d, wb_en;

  scrub_state_t      scrub_state, state_d;
  logic [IW-1:0]     int_cnt, int_cnt_d;
  logic [ADDR_W-1:0] scrub_ptr, ptr_d;
  logic [CODE_W-1:0] sc_code_q, sc_fix_code;
  logic [DATA_W-1:0] sc_data;
  logic              sc_stale, sc_s, sc_d, sc_rd, fix_we;

  secded_codec #(.DATA_W(DATA_W)) u_wr_codec (
    .enc_data(wdata), .enc_code(wr_code), .dec_code('0),
    .dec_data(unused_wr_data), .s_err(unused_wr_s), .d_err(unused_wr_d)
  );

  // Read and scrub decoders re-encode their own corrected data for the repair write.
  secded_codec #(.DATA_W(DATA_W)) u_rd_codec (
    .enc_data(rdata), .enc_code(rd_fix_code), .dec_code(rd_code_q),
    .dec_data(rdata), .s_err(rd_s), .d_err(rd_d)
  );

  secded_codec #(.DATA_W(DATA_W)) u_sc_codec (
    .enc_data(sc_data), .enc_code(sc_fix_code), .dec_code(sc_code_q),
    .dec_data(sc_data), .s_err(sc_s), .d_err(sc_d)
  );

  assign s_err = rvalid & rd_s;
  assign d_err = rvalid & rd_d;
  // A same-cycle CPU write to the read address makes the captured word stale: never write it back.
  assign wb_en = rvalid & rd_s & ~we & ~rd_stale;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      rd_code_q <= '0;
      rd_addr_q <= '0;
      rvalid    <= 1'b0;
      rd_stale  <= 1'b0;
    end else begin
      rvalid   <= re;
      rd_stale <= we && (waddr == raddr);
      if (re) begin
        rd_code_q <= mem[raddr];
        rd_addr_q <= raddr;
      end
    end
  end

  // NOTE: the array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wb_en)  mem[rd_addr_q] <= rd_fix_code;
    if (fix_we) mem[scrub_ptr] <= sc_fix_code;
    if (we)     mem[waddr]     <= wr_code;
  end

  always_comb begin
    state_d   = scrub_state;
    int_cnt_d = int_cnt;
    ptr_d     = scrub_ptr;
    sc_rd     = 1'b0;
    fix_we    = 1'b0;
    if (!scrub_en) begin
      state_d   = WAIT;
      int_cnt_d = '0;
    end else begin
      unique case (scrub_state)
        WAIT: begin
          if (int_cnt == IW'(SCRUB_INTERVAL - 1)) begin
            state_d   = READ;
            int_cnt_d = '0;
          end else begin
            int_cnt_d = int_cnt + 1'b1;
          end
        end
        READ: begin
          if (!re) begin
            sc_rd   = 1'b1;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (sc_s) begin
            state_d = FIX;
          end else begin
            ptr_d   = scrub_ptr + 1'b1;
            state_d = WAIT;
          end
        end
        FIX: begin
          if (!we) begin
            fix_we  = ~sc_stale;
            ptr_d   = scrub_ptr + 1'b1;
            state_d = WAIT;
          end else if (waddr == scrub_ptr) begin
            ptr_d   = scrub_ptr + 1'b1;
            state_d = WAIT;
          end
        end
        default: state_d = WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scrub_state <= WAIT;
      int_cnt     <= '0;
      scrub_ptr   <= '0;
      sc_code_q   <= '0;
      sc_stale    <= 1'b0;
    end else begin
      scrub_state <= state_d;
      int_cnt     <= int_cnt_d;
      scrub_ptr   <= ptr_d;
      if (sc_rd) begin
        sc_code_q <= mem[scrub_ptr];
        sc_stale  <= we && (waddr == scrub_ptr);
      end else if (scrub_state == CHECK && we && waddr == scrub_ptr) begin
        sc_stale <= 1'b1;
      end
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic a, input logic b);
    logic [CNT_W:0] sum;
    sum = {1'b0, c} + {{CNT_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scrub_s_cnt <= '0;
      scrub_d_cnt <= '0;
      err_addr    <= '0;
    end else begin
      if (cnt_clr) begin
        scrub_s_cnt <= '0;
        scrub_d_cnt <= '0;
      end else begin
        scrub_s_cnt <= sat_inc(scrub_s_cnt, s_err, (scrub_state == CHECK) & sc_s);
        scrub_d_cnt <= sat_inc(scrub_d_cnt, d_err, (scrub_state == CHECK) & sc_d);
      end
      if (s_err || d_err)
        err_addr <= rd_addr_q;
      else if (scrub_state == CHECK && (sc_s || sc_d))
        err_addr <= scrub_ptr;
    end
  end

endmodule

// File: tb/tb_ecc_scrub_memory.sv
// Scoreboard bench: reads push expected responses, a monitor pops and compares on rvalid.
module tb_ecc_scrub_memory;
  import ecc_scrub_memory_pkg::*;

  localparam int DATA_W = 32, ADDR_W = 4, SCRUB_INTERVAL = 4, CNT_W = 4;

  logic              clk = 1'b0;
  logic              rst, we, re, scrub_en, cnt_clr, rvalid, s_err, d_err;
  logic [ADDR_W-1:0] waddr, raddr, err_addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [CNT_W-1:0]  scrub_s_cnt, scrub_d_cnt;

  ecc_scrub_memory #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCRUB_INTERVAL(SCRUB_INTERVAL),
                     .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(re), .raddr(raddr),
    .rdata(rdata), .rvalid(rvalid), .s_err(s_err), .d_err(d_err), .scrub_en(scrub_en),
    .scrub_s_cnt(scrub_s_cnt), .scrub_d_cnt(scrub_d_cnt), .err_addr(err_addr),
    .cnt_clr(cnt_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              s;
    logic              d;
    string             tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_rvalid", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.tag, "_rdata"}, rdata, mon_e.data);
        check({mon_e.tag, "_s_err"}, s_err, mon_e.s);
        check({mon_e.tag, "_d_err"}, d_err, mon_e.d);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [DATA_W-1:0] d);
    we = 1'b1; waddr = ADDR_W'(a); wdata = d;
    tick(1);
    we = 1'b0;
  endtask

  task automatic expect_rd(input logic [DATA_W-1:0] d, input logic s, input logic dd,
                           input string tag);
    exp_t e;
    e.data = d; e.s = s; e.d = dd; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic rd(input int a, input logic [DATA_W-1:0] d, input logic s, input logic dd,
                    input string tag);
    expect_rd(d, s, dd, tag);
    re = 1'b1; raddr = ADDR_W'(a);
    tick(1);
    re = 1'b0;
  endtask

  task automatic flip(input int a, input int b);
    dut.mem[a][b] = ~dut.mem[a][b];
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic wait_fix(input string tag);
    int n;
    n = 0;
    while (dut.scrub_state != FIX && n < 200) begin
      tick(1);
      n++;
    end
    check({tag, "_fix_reached"}, 64'(n < 200), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; scrub_en = 1'b0; cnt_clr = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;
    tick(3);
    check("rst_rdata", rdata, 64'd0);
    check("rst_rvalid", rvalid, 64'd0);
    check("rst_s_err", s_err, 64'd0);
    check("rst_d_err", d_err, 64'd0);
    check("rst_s_cnt", scrub_s_cnt, 64'd0);
    check("rst_d_cnt", scrub_d_cnt, 64'd0);
    check("rst_err_addr", err_addr, 64'd0);
    check("rst_ptr", dut.scrub_ptr, 64'd0);
    rst = 1'b0;
    tick(1);

    // Plain write/read, back-to-back reads, read-first collision.
    wr(5, 32'hDEADBEEF);
    wr(6, 32'h0BADF00D);
    rd(5, 32'hDEADBEEF, 1'b0, 1'b0, "t1_a5");
    rd(6, 32'h0BADF00D, 1'b0, 1'b0, "t1_a6");
    expect_rd(32'h0BADF00D, 1'b0, 1'b0, "t1_rfirst");
    we = 1'b1; waddr = 4'd6; wdata = 32'h11111111;
    re = 1'b1; raddr = 4'd6;
    tick(1);
    we = 1'b0; re = 1'b0;
    rd(6, 32'h11111111, 1'b0, 1'b0, "t1_new");
    tick(2);

    // Single error corrected on read, then written back.
    wr(7, 32'h12345678);
    flip(7, 3);
    rd(7, 32'h12345678, 1'b1, 1'b0, "t2_single");
    tick(2);
    check("t2_s_cnt", scrub_s_cnt, 64'd1);
    check("t2_err_addr", err_addr, 64'd7);
    rd(7, 32'h12345678, 1'b0, 1'b0, "t2_wb");
    tick(2);

    // Double error: raw data returned, never repaired.
    wr(9, 32'h000000F0);
    flip(9, 3);
    flip(9, 5);
    rd(9, 32'h000000F3, 1'b0, 1'b1, "t3_double");
    tick(2);
    check("t3_d_cnt", scrub_d_cnt, 64'd1);
    check("t3_s_cnt", scrub_s_cnt, 64'd1);
    check("t3_err_addr", err_addr, 64'd9);
    rd(9, 32'h000000F3, 1'b0, 1'b1, "t3_again");
    tick(2);
    check("t3_d_cnt2", scrub_d_cnt, 64'd2);

    // Scrubber repairs words 0..7; 8 faulty visits of 7 cycles + 8 clean of 6 = 104 cycles.
    for (int i = 0; i < 16; i++) wr(i, 32'h10000000 + 32'(i) * 32'h0101);
    for (int i = 0; i < 8; i++) flip(i, i * 4 + 1);
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    scrub_en = 1'b1;
    tick(104);
    scrub_en = 1'b0;
    check("t4_ptr_wrap", dut.scrub_ptr, 64'd0);
    check("t4_state", dut.scrub_state, WAIT);
    check("t4_s_cnt", scrub_s_cnt, 64'd8);
    check("t4_d_cnt", scrub_d_cnt, 64'd0);
    check("t4_err_addr", err_addr, 64'd7);
    for (int i = 0; i < 16; i++)
      rd(i, 32'h10000000 + 32'(i) * 32'h0101, 1'b0, 1'b0, $sformatf("t4_w%0d", i));
    tick(2);

    // Saturation of the double counter, then clear beats a same-cycle error.
    flip(9, 3);
    flip(9, 5);
    for (int i = 0; i < 17; i++)
      rd(9, 32'h10000909 ^ 32'h3, 1'b0, 1'b1, "t5_sat");
    tick(2);
    check("t5_d_sat", scrub_d_cnt, 64'd15);
    rd(9, 32'h10000909 ^ 32'h3, 1'b0, 1'b1, "t5_clr");
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    check("t5_d_clr", scrub_d_cnt, 64'd0);
    check("t5_err_addr", err_addr, 64'd9);

    // FIX on word 2 cancelled by a CPU write to the same word.
    flip(2, 10);
    pulse_rst();
    scrub_en = 1'b1;
    wait_fix("t6a");
    check("t6a_ptr", dut.scrub_ptr, 64'd2);
    we = 1'b1; waddr = 4'd2; wdata = 32'hA5A5A5A5;
    tick(1);
    we = 1'b0; scrub_en = 1'b0;
    check("t6a_ptr_next", dut.scrub_ptr, 64'd3);
    check("t6a_s_cnt", scrub_s_cnt, 64'd1);
    rd(2, 32'hA5A5A5A5, 1'b0, 1'b0, "t6a_new");
    tick(2);

    // FIX waits one cycle for a write elsewhere, then repairs.
    flip(2, 10);
    pulse_rst();
    scrub_en = 1'b1;
    wait_fix("t6b");
    we = 1'b1; waddr = 4'd3; wdata = 32'h33333333;
    tick(1);
    we = 1'b0;
    check("t6b_hold", dut.scrub_state, FIX);
    tick(1);
    scrub_en = 1'b0;
    check("t6b_done", dut.scrub_state, WAIT);
    check("t6b_ptr", dut.scrub_ptr, 64'd3);
    rd(2, 32'hA5A5A5A5, 1'b0, 1'b0, "t6b_fixed");
    rd(3, 32'h33333333, 1'b0, 1'b0, "t6b_other");
    tick(2);

    // Reset in FIX: state and outputs clear, array untouched.
    flip(2, 10);
    pulse_rst();
    scrub_en = 1'b1;
    wait_fix("t7");
    rst = 1'b1;
    tick(1);
    scrub_en = 1'b0;
    check("t7_state", dut.scrub_state, WAIT);
    check("t7_ptr", dut.scrub_ptr, 64'd0);
    check("t7_s_cnt", scrub_s_cnt, 64'd0);
    check("t7_err_addr", err_addr, 64'd0);
    check("t7_rvalid", rvalid, 64'd0);
    rst = 1'b0;
    tick(1);
    rd(2, 32'hA5A5A5A5, 1'b1, 1'b0, "t7_kept");
    rd(3, 32'h33333333, 1'b0, 1'b0, "t7_other");
    tick(3);

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
